// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the pipeline hazard/flow controller.
// State encoding is visible on the status port, so the values are fixed.
package pipeline_ctrl_pkg;

   localparam int unsigned HOLD_CYCLES_DEF = 2;
   localparam int unsigned REG_W_DEF       = 4;
   localparam int unsigned CNT_W           = 16;

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StRun     = 2'd1,
      StMemWait = 2'd2,
      StHalted  = 2'd3
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Pipeline-side bundle: hazard inputs in, stage controls and status out.
// master = pipeline datapath, slave = controller.
interface pipeline_controller_if
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF
) ();

   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_is_load;
   logic             ex_br_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             halt_req;
   logic             cnt_clr;

   logic             pc_en;
   logic             pc_sel;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_en;
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_br_taken,
             mem_req, mem_ready, halt_req, cnt_clr,
      input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             halted, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_br_taken,
             mem_req, mem_ready, halt_req, cnt_clr,
      output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             halted, state, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard detect between the ID and EX instructions.
// Register 0 is hardwired zero, so a load targeting it never creates a dependency.
module load_use_detect #(
   parameter int unsigned REG_W = 4
) (
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_is_load_i,
   output logic             hazard_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
   assign hazard_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline flow controller: Mealy stall/flush FSM (hold, run, memory wait, halt)
// plus saturating stall and flush performance counters.
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned REG_W       = REG_W_DEF,
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input logic              clk,
   input logic              reset,
   pipeline_controller_if.slave bus
);

   if (WIDTH == 0 || HOLD_CYCLES == 0) begin : g_bad_param
      $error("pipeline_controller: WIDTH and HOLD_CYCLES must be >= 1");
   end

   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic load_use;
   logic pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
   logic flush_inc, stall_inc;

   load_use_detect #(
      .REG_W (REG_W)
   ) u_load_use_detect (
      .id_rs1_i     (bus.id_rs1),
      .id_rs2_i     (bus.id_rs2),
      .id_use_rs1_i (bus.id_use_rs1),
      .id_use_rs2_i (bus.id_use_rs2),
      .ex_rd_i      (bus.ex_rd),
      .ex_is_load_i (bus.ex_is_load),
      .hazard_o     (load_use)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StHold;
         hold_cnt_q <= HoldLoad;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      pc_en       = 1'b1;
      pc_sel      = 1'b0;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b1;
      flush_inc   = 1'b0;

      unique case (state_q)
         StHold: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (hold_cnt_q == '0) begin
               state_d = StRun;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end

         StRun, StMemWait: begin
            if ((state_q == StRun && bus.mem_req && !bus.mem_ready) ||
                (state_q == StMemWait && !bus.mem_ready)) begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               state_d   = StMemWait;
            end else begin
               // A taken branch squashes the dependent instruction, so no stall is needed.
               if (bus.ex_br_taken) begin
                  pc_sel      = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
               if (state_q == StMemWait) begin
                  state_d = StRun;
               end else if (bus.halt_req) begin
                  state_d = StHalted;
               end
            end
         end

         StHalted: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            if (bus.ex_br_taken) begin
               pc_en       = 1'b1;
               pc_sel      = 1'b1;
               id_ex_flush = 1'b1;
               flush_inc   = 1'b1;
            end
            if (!bus.halt_req) begin
               state_d = StRun;
            end
         end

         default: state_d = StHold;
      endcase
   end

   assign stall_inc = !pc_en && (state_q == StRun || state_q == StMemWait);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (bus.cnt_clr) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.pc_sel      = pc_sel;
   assign bus.if_id_en    = if_id_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_en    = id_ex_en;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.ex_mem_en   = ex_mem_en;
   assign bus.halted      = (state_q == StHalted);
   assign bus.state       = state_q;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: stimulus pushes expected controls per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_controller;

   // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted}
   localparam logic [7:0] C_HOLD   = 8'b0011_1110;
   localparam logic [7:0] C_RUN    = 8'b1010_1010;
   localparam logic [7:0] C_STALL  = 8'b0000_1110;
   localparam logic [7:0] C_BR     = 8'b1111_1110;
   localparam logic [7:0] C_MW     = 8'b0000_0000;
   localparam logic [7:0] C_HALT   = 8'b0011_1011;
   localparam logic [7:0] C_HALTBR = 8'b1111_1111;

   typedef struct packed {
      logic [7:0]  ctl;
      logic [1:0]  st;
      logic        cc;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   exp_t   exp_q[$];
   string  name_q[$];
   int     total = 0;
   int     bad = 0;

   pipeline_controller_if #(.REG_W(4)) bus ();

   pipeline_controller #(
      .WIDTH       (16),
      .REG_W       (4),
      .HOLD_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         string       nm;
         logic [7:0]  act;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.if_id_flush,
                bus.id_ex_en, bus.id_ex_flush, bus.ex_mem_en, bus.halted};
         total++;
         if (act !== e.ctl) begin
            bad++;
            $display("FAIL %s ctl: got %b want %b", nm, act, e.ctl);
         end
         total++;
         if (bus.state !== e.st) begin
            bad++;
            $display("FAIL %s state: got %0d want %0d", nm, bus.state, e.st);
         end
         if (e.cc) begin
            total++;
            if (bus.stall_cnt !== e.sc) begin
               bad++;
               $display("FAIL %s stall_cnt: got %h want %h", nm, bus.stall_cnt, e.sc);
            end
            total++;
            if (bus.flush_cnt !== e.fc) begin
               bad++;
               $display("FAIL %s flush_cnt: got %h want %h", nm, bus.flush_cnt, e.fc);
            end
         end
      end
   end

   task automatic clr_in();
      bus.id_rs1      = '0;
      bus.id_rs2      = '0;
      bus.id_use_rs1  = 1'b0;
      bus.id_use_rs2  = 1'b0;
      bus.ex_rd       = '0;
      bus.ex_is_load  = 1'b0;
      bus.ex_br_taken = 1'b0;
      bus.mem_req     = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.halt_req    = 1'b0;
      bus.cnt_clr     = 1'b0;
   endtask

   // Queue the expectation for the current cycle, then advance to just after the next edge.
   task automatic cyc(input string nm, input logic [7:0] ctl, input logic [1:0] st,
                      input logic cc = 1'b0, input logic [15:0] sc = '0,
                      input logic [15:0] fc = '0);
      exp_t e;
      e.ctl = ctl;
      e.st  = st;
      e.cc  = cc;
      e.sc  = sc;
      e.fc  = fc;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic release_to_run();
      reset = 1'b0;
      cyc("hold0", C_HOLD, 2'd0, 1'b1, 16'd0, 16'd0);
      cyc("hold1", C_HOLD, 2'd0);
      cyc("run0", C_RUN, 2'd1);
   endtask

   task automatic do_reset();
      clr_in();
      reset = 1'b1;
      cyc("rst_a", C_HOLD, 2'd0, 1'b1, 16'd0, 16'd0);
      cyc("rst_b", C_HOLD, 2'd0, 1'b1, 16'd0, 16'd0);
      release_to_run();
   endtask

   initial begin
      clr_in();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Load-use detection variants
      do_reset();
      bus.ex_is_load = 1'b1; bus.ex_rd = 4'd3; bus.id_rs2 = 4'd3; bus.id_use_rs2 = 1'b1;
      cyc("lu_rs2", C_STALL, 2'd1);
      bus.ex_rd = 4'd0; bus.id_rs2 = 4'd0;
      cyc("lu_rd0", C_RUN, 2'd1, 1'b1, 16'd1, 16'd0);
      bus.ex_rd = 4'd5; bus.id_rs2 = 4'd5; bus.id_use_rs2 = 1'b0;
      cyc("lu_nouse", C_RUN, 2'd1);
      bus.id_use_rs2 = 1'b1; bus.ex_is_load = 1'b0;
      cyc("lu_noload", C_RUN, 2'd1);
      clr_in();
      bus.ex_is_load = 1'b1; bus.ex_rd = 4'd9; bus.id_rs1 = 4'd9; bus.id_use_rs1 = 1'b1;
      cyc("lu_rs1", C_STALL, 2'd1);
      clr_in();
      cyc("lu_done", C_RUN, 2'd1, 1'b1, 16'd2, 16'd0);

      // Branch beats load-use
      do_reset();
      bus.ex_is_load = 1'b1; bus.ex_rd = 4'd3; bus.id_rs2 = 4'd3; bus.id_use_rs2 = 1'b1;
      bus.ex_br_taken = 1'b1;
      cyc("br_lu", C_BR, 2'd1);
      clr_in();
      cyc("br_done", C_RUN, 2'd1, 1'b1, 16'd0, 16'd1);

      // Memory wait
      do_reset();
      bus.mem_req = 1'b1;
      cyc("mw1", C_MW, 2'd1);
      cyc("mw2", C_MW, 2'd2);
      cyc("mw3", C_MW, 2'd2);
      bus.mem_ready = 1'b1;
      cyc("mw_rdy", C_RUN, 2'd2);
      clr_in();
      cyc("mw_done", C_RUN, 2'd1, 1'b1, 16'd3, 16'd0);
      bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
      cyc("mw_hit", C_RUN, 2'd1);
      bus.mem_ready = 1'b0;
      cyc("mw_b1", C_MW, 2'd1);
      bus.mem_ready = 1'b1; bus.ex_br_taken = 1'b1;
      cyc("mw_br", C_BR, 2'd2);
      clr_in();
      cyc("mw_br_done", C_RUN, 2'd1, 1'b1, 16'd4, 16'd1);

      // Halt with a branch on the second halted cycle
      do_reset();
      bus.halt_req = 1'b1;
      cyc("halt_in", C_RUN, 2'd1);
      cyc("halted1", C_HALT, 2'd3);
      bus.ex_br_taken = 1'b1;
      cyc("halt_br", C_HALTBR, 2'd3);
      bus.ex_br_taken = 1'b0;
      cyc("halted3", C_HALT, 2'd3);
      bus.halt_req = 1'b0;
      cyc("halt_out", C_HALT, 2'd3);
      cyc("halt_run", C_RUN, 2'd1, 1'b1, 16'd0, 16'd1);

      // Asynchronous reset out of MEM_WAIT
      bus.mem_req = 1'b1;
      cyc("mwr1", C_MW, 2'd1);
      cyc("mwr2", C_MW, 2'd2);
      reset = 1'b1;
      cyc("mw_rst", C_HOLD, 2'd0, 1'b1, 16'd0, 16'd0);
      clr_in();
      release_to_run();

      // Stall counter saturation and clear-beats-increment
      do_reset();
      bus.ex_br_taken = 1'b1;
      cyc("sat_br", C_BR, 2'd1);
      bus.ex_br_taken = 1'b0;
      bus.mem_req = 1'b1;
      repeat (65534) begin
         @(posedge clk);
         #1;
      end
      cyc("sat_a", C_MW, 2'd2, 1'b1, 16'hFFFE, 16'd1);
      cyc("sat_b", C_MW, 2'd2, 1'b1, 16'hFFFF, 16'd1);
      cyc("sat_c", C_MW, 2'd2, 1'b1, 16'hFFFF, 16'd1);
      bus.cnt_clr = 1'b1;
      cyc("sat_clr", C_MW, 2'd2, 1'b1, 16'hFFFF, 16'd1);
      bus.cnt_clr = 1'b0;
      cyc("clr0", C_MW, 2'd2, 1'b1, 16'd0, 16'd0);
      cyc("clr1", C_MW, 2'd2, 1'b1, 16'd1, 16'd0);
      bus.mem_req = 1'b0; bus.mem_ready = 1'b1;
      cyc("sat_exit", C_RUN, 2'd2);
      clr_in();
      cyc("sat_run", C_RUN, 2'd1, 1'b1, 16'd2, 16'd0);

      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
